audio_sample_feeder: RTL and testbench
======================================

# audio_sample_feeder

Paces decoded PCM audio into the PWM output stage. Accepts signed 16-bit samples over a ready/valid stream from the decoder, buffers them in a small FIFO, and releases one sample per sample period from an exact fractional-rate tick. Each released sample is attenuated, converted to 8-bit offset-binary, and held on `music_data` for the 8-bit PWM modulator immediately downstream.

## Interface
- `CLK_HZ`, 100_000_000: system clock frequency.
- `SAMPLE_HZ`, 44_100: output sample rate; must satisfy 0 < SAMPLE_HZ < CLK_HZ.
- `DEPTH`, 16: FIFO depth in samples; power of two, at least 2.

- `clk` in 1: system clock; all logic on its rising edge.
- `reset` in 1: reset, synchronous, active-high.
- `s_data` in 16: signed two's-complement PCM sample.
- `s_valid` in 1: `s_data` is valid.
- `s_ready` out 1: FIFO can accept a sample.
- `enable` in 1: playback enable.
- `volume` in 3: attenuation; arithmetic right shift by 0–7.
- `music_data` out 8: unsigned sample to the PWM stage.
- `sample_tick` out 1: one-cycle pulse, one per sample period.
- `underrun` out 1: sticky flag, set when a tick finds the FIFO empty.
- `fill` out $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- **Push.** A push occurs in any cycle with `s_valid && s_ready`. `s_ready` = !full and is 0 while `reset` is high.
- **Tick generation.** Accumulator `acc` is $clog2(CLK_HZ)+1 bits wide. Every cycle:
  - if `acc + SAMPLE_HZ >= CLK_HZ`: `acc <= acc + SAMPLE_HZ - CLK_HZ` and the tick fires;
  - otherwise `acc <= acc + SAMPLE_HZ`.
  - Long-run average rate is exactly SAMPLE_HZ, with no drift.
  - The tick runs regardless of `enable`.
- **On a tick with `enable`=1 and the FIFO non-empty:**
  - pop the head sample `x`;
  - `y = x >>> volume` (sign-preserving);
  - `music_data <= {~y[15], y[14:8]}`.
- **On a tick with `enable`=1 and the FIFO empty:** `music_data <= 8'h80` (midscale) and `underrun <= 1`.
- **On a tick with `enable`=0:** `music_data <= 8'h80`, no pop, and `underrun` is unchanged.
- **Between ticks:** `music_data` holds its value.
- **Simultaneous push and pop:** both take effect and `fill` is unchanged.
- **Push into an empty FIFO in a tick cycle:** no bypass. The tick counts as an underrun, and the pushed sample is popped on the next tick.
- **Full FIFO:** `s_ready`=0. A pop in that cycle does not raise `s_ready` until the next cycle.
- **Pointers:** wrap modulo DEPTH. `fill` ranges 0..DEPTH.

## Timing
- **Reset values:** `music_data`=8'h80, `sample_tick`=0, `underrun`=0, `fill`=0, `s_ready`=0 during reset, `acc`=0.
- **`s_ready`:** goes to 1 in the first cycle after reset deasserts.
- **Tick output:** `sample_tick` is registered. It is high in cycle T+1 when the tick condition was evaluated in cycle T.
- **Output update:** `music_data` and `underrun` update in the same cycle that `sample_tick` is high.
- **Push-to-output latency:** a sample pushed in cycle P becomes eligible on the first tick evaluated in cycle > P.
- **Reset mid-stream:** FIFO is flushed, `acc` is cleared, and the output returns to midscale in the next cycle.

## Structure
- **Package `audio_pkg`:**
  - `typedef logic signed [15:0] pcm_t;`
  - `typedef logic [7:0] pwm_sample_t;`
  - `localparam pwm_sample_t MIDSCALE = 8'h80;`
- **Sub-module `sample_fifo`:** synchronous, single-clock FIFO parameterised by DEPTH and element type. It exposes push, pop, full, empty and count.
- **Top level:** the accumulator, conversion logic and output registers stay in the top module.

## Test plan
All scenarios use CLK_HZ=10, SAMPLE_HZ=3 unless stated.
- **Tick cadence.** Release reset, `enable`=1, FIFO empty → `sample_tick` high in cycles 4, 7 and 10 after release (3 per 10 cycles, repeating). `underrun` becomes 1 at the first tick, and `music_data` stays 8'h80.
- **Conversion at `volume`=0.** Push 16'h0000, 16'h7FFF, 16'h8000, 16'h1234 → on successive ticks `music_data` = 8'h80, 8'hFF, 8'h00, 8'h92.
- **Attenuation at `volume`=1.** Push 16'h8000, then 16'h7FFF → 8'h40, then 8'hBF. At `volume`=7, 16'h8000 → 8'h7F.
- **Full FIFO.** DEPTH=4, `enable`=0, hold `s_valid`=1 → exactly 4 pushes accepted, `fill`=4 and `s_ready`=0. Set `enable`=1: after the next tick `fill`=3 and `s_ready` returns to 1 one cycle later.
- **Push/pop collision.** Empty FIFO, push in the same cycle the tick is evaluated → `music_data`=8'h80 and `underrun`=1 on that tick. The sample appears on the following tick.
- **Reset mid-stream.** 3 samples queued, assert `reset` for 1 cycle → `fill`=0, `music_data`=8'h80, `underrun`=0, and the next tick arrives 4 cycles after release.
- **Drift check.** Default parameters, over 10^8 cycles → exactly 44_100 ticks.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types and the PCM-to-PWM sample conversion for the audio output path.
package audio_pkg;

  typedef logic signed [15:0] pcm_t;
  typedef logic [7:0]         pwm_sample_t;

  localparam pwm_sample_t MIDSCALE = 8'h80;

  // Attenuate by an arithmetic shift, then keep the top byte in offset-binary form.
  function automatic pwm_sample_t pcm_to_pwm(input pcm_t x, input logic [2:0] shift);
    pcm_t y;
    y = x >>> shift;
    return {~y[15], y[14:8]};
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Single-clock synchronous FIFO; head element is presented combinationally on pop_data_o.
module sample_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter type         elem_t = logic [15:0]
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  elem_t                    push_data_i,
  input  logic                     pop_i,
  output elem_t                    pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  elem_t           mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/audio_sample_feeder.sv
// Buffers decoded PCM samples and releases one per sample period, attenuated and
// converted to offset-binary, to the 8-bit PWM modulator.
module audio_sample_feeder
  import audio_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned SAMPLE_HZ = 44_100,
  parameter int unsigned DEPTH     = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  pcm_t                    s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic                    enable,
  input  logic [2:0]              volume,
  output pwm_sample_t             music_data,
  output logic                    sample_tick,
  output logic                    underrun,
  output logic [$clog2(DEPTH):0]  fill
);

  localparam int unsigned ACC_W = $clog2(CLK_HZ) + 1;
  localparam logic [ACC_W-1:0] ACC_INC = ACC_W'(SAMPLE_HZ);
  localparam logic [ACC_W-1:0] ACC_LIM = ACC_W'(CLK_HZ);

  logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
  logic             tick_c;
  logic             tick_q;
  pwm_sample_t      music_q, music_d;
  logic             underrun_q, underrun_d;

  logic             push_c, pop_c;
  logic             fifo_full, fifo_empty;
  pcm_t             fifo_head;

  assign s_ready     = !reset && !fifo_full;
  assign push_c      = s_valid && s_ready;
  assign music_data  = music_q;
  assign sample_tick = tick_q;
  assign underrun    = underrun_q;

  sample_fifo #(
    .DEPTH  (DEPTH),
    .elem_t (pcm_t)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push_c),
    .push_data_i (s_data),
    .pop_i       (pop_c),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fill)
  );

  // Fractional-rate accumulator; the sum fits in ACC_W bits since SAMPLE_HZ < CLK_HZ.
  always_comb begin
    acc_sum    = acc_q + ACC_INC;
    tick_c     = (acc_sum >= ACC_LIM);
    acc_d      = tick_c ? (acc_sum - ACC_LIM) : acc_sum;
    music_d    = music_q;
    underrun_d = underrun_q;
    pop_c      = 1'b0;
    if (tick_c) begin
      if (!enable) begin
        music_d = MIDSCALE;
      end else if (fifo_empty) begin
        music_d    = MIDSCALE;
        underrun_d = 1'b1;
      end else begin
        pop_c   = 1'b1;
        music_d = pcm_to_pwm(fifo_head, volume);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q      <= '0;
      tick_q     <= 1'b0;
      music_q    <= MIDSCALE;
      underrun_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      tick_q     <= tick_c;
      music_q    <= music_d;
      underrun_q <= underrun_d;
    end
  end

endmodule

// File: tb/tb_audio_sample_feeder.sv
// Directed bench for audio_sample_feeder at CLK_HZ=10, SAMPLE_HZ=3, DEPTH=4 with an output scoreboard.
module tb_audio_sample_feeder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        enable = 1'b0;
  logic [2:0]  volume = '0;
  logic [7:0]  music_data;
  logic        sample_tick;
  logic        underrun;
  logic [2:0]  fill;

  int          checks = 0;
  int          passed = 0;
  logic [7:0]  exp_q [$];
  logic        prev_ready;

  always #5 clk = ~clk;

  audio_sample_feeder #(
    .CLK_HZ    (10),
    .SAMPLE_HZ (3),
    .DEPTH     (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .enable      (enable),
    .volume      (volume),
    .music_data  (music_data),
    .sample_tick (sample_tick),
    .underrun    (underrun),
    .fill        (fill)
  );

  // Reference conversion via integer offset arithmetic.
  function automatic logic [7:0] ref_pwm(input logic [15:0] x, input int sh);
    int y;
    y = int'($signed(x));
    y = y >>> sh;
    return 8'((y + 32768) >>> 8);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_true(input string tag, input logic cond);
    checks++;
    assert (cond === 1'b1) passed++;
    else $error("FAIL %s: observed %b expected 1", tag, cond);
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      prev_ready = s_ready;
      step();
      n++;
    end while (!sample_tick && n < 40);
    chk_true("tick_seen", sample_tick);
  endtask

  task automatic expect_ticks(input int k);
    int n;
    for (int i = 0; i < k; i++) begin
      wait_tick(n);
      if (exp_q.size() == 0) chk_true("scoreboard_nonempty", 1'b0);
      else chk("music", 32'(music_data), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic push_sample(input logic [15:0] d, input logic [7:0] e);
    logic took;
    took    = 1'b0;
    s_data  = d;
    s_valid = 1'b1;
    for (int i = 0; i < 20 && !took; i++) begin
      took = s_ready;
      step();
    end
    s_valid = 1'b0;
    chk_true("push_accept", took);
    if (took) exp_q.push_back(e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int cnt;
    logic [15:0] r;
    int v;

    // Reset state
    reset = 1'b1;
    step();
    step();
    chk("rst_music", 32'(music_data), 32'h80);
    chk("rst_tick", 32'(sample_tick), 32'h0);
    chk("rst_underrun", 32'(underrun), 32'h0);
    chk("rst_fill", 32'(fill), 32'h0);
    chk("rst_ready", 32'(s_ready), 32'h0);
    reset  = 1'b0;
    enable = 1'b1;
    #1;
    chk("ready_after_reset", 32'(s_ready), 32'h1);

    // Tick cadence with empty FIFO
    for (int c = 1; c <= 10; c++) begin
      logic e;
      step();
      e = (c == 4) || (c == 7) || (c == 10);
      chk("cadence", 32'(sample_tick), 32'(e));
      if (c == 3) chk("underrun_before_tick", 32'(underrun), 32'h0);
      if (c == 4) chk("underrun_first_tick", 32'(underrun), 32'h1);
    end
    chk("cadence_music", 32'(music_data), 32'h80);

    // Push collides with tick evaluation into an empty FIFO
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    step();
    step();
    step();
    chk("collide_underrun_cleared", 32'(underrun), 32'h0);
    s_data  = 16'h1234;
    s_valid = 1'b1;
    chk("collide_ready", 32'(s_ready), 32'h1);
    step();
    s_valid = 1'b0;
    chk("collide_tick", 32'(sample_tick), 32'h1);
    chk("collide_music", 32'(music_data), 32'h80);
    chk("collide_underrun", 32'(underrun), 32'h1);
    chk("collide_fill", 32'(fill), 32'h1);
    exp_q.push_back(8'h92);
    expect_ticks(1);
    enable = 1'b0;
    chk("collide_fill_after", 32'(fill), 32'h0);

    // Conversion at volume 0
    volume = 3'd0;
    push_sample(16'h0000, 8'h80);
    push_sample(16'h7FFF, 8'hFF);
    push_sample(16'h8000, 8'h00);
    push_sample(16'h1234, 8'h92);
    chk("conv_fill", 32'(fill), 32'h4);
    enable = 1'b1;
    expect_ticks(4);
    enable = 1'b0;
    chk("underrun_sticky", 32'(underrun), 32'h1);
    chk("conv_fill_after", 32'(fill), 32'h0);

    // Attenuation
    volume = 3'd1;
    push_sample(16'h8000, 8'h40);
    push_sample(16'h7FFF, 8'hBF);
    enable = 1'b1;
    expect_ticks(2);
    enable = 1'b0;
    volume = 3'd7;
    push_sample(16'h8000, 8'h7F);
    enable = 1'b1;
    expect_ticks(1);
    enable = 1'b0;

    // Random samples through the reference model
    v = int'($urandom_range(0, 7));
    volume = 3'(v);
    for (int i = 0; i < 3; i++) begin
      r = 16'($urandom);
      push_sample(r, ref_pwm(r, v));
    end
    enable = 1'b1;
    expect_ticks(3);
    enable = 1'b0;

    // Full FIFO with s_valid held
    volume  = 3'd0;
    s_data  = 16'hABCD;
    s_valid = 1'b1;
    cnt     = 0;
    for (int i = 0; i < 10; i++) begin
      if (s_ready) begin
        cnt++;
        exp_q.push_back(ref_pwm(16'hABCD, 0));
      end
      step();
    end
    s_valid = 1'b0;
    chk("full_accepted", 32'(cnt), 32'd4);
    chk("full_fill", 32'(fill), 32'h4);
    chk("full_ready", 32'(s_ready), 32'h0);
    enable = 1'b1;
    wait_tick(n);
    chk("ready_in_pop_cycle", 32'(prev_ready), 32'h0);
    chk("full_fill_after_pop", 32'(fill), 32'h3);
    chk("ready_after_pop", 32'(s_ready), 32'h1);
    if (exp_q.size() == 0) chk_true("scoreboard_nonempty", 1'b0);
    else chk("full_music", 32'(music_data), 32'(exp_q.pop_front()));
    enable = 1'b0;

    // Reset mid-stream with 3 samples queued
    reset = 1'b1;
    step();
    exp_q.delete();
    chk("midrst_fill", 32'(fill), 32'h0);
    chk("midrst_music", 32'(music_data), 32'h80);
    chk("midrst_underrun", 32'(underrun), 32'h0);
    chk("midrst_tick", 32'(sample_tick), 32'h0);
    chk("midrst_ready", 32'(s_ready), 32'h0);
    reset = 1'b0;
    #1;
    wait_tick(n);
    chk("midrst_first_tick_cycle", 32'(n), 32'd4);

    // Long-run rate: exactly 3 ticks per 10 cycles
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (sample_tick) cnt++;
    end
    chk("drift_ticks", 32'(cnt), 32'd300);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
